// File: rtl/backtrack_ctrl.sv
// backtrack_ctrl: chronological backtracking sequencer for the DPLL core.
// Walks the trace stack from the top, unassigning forced entries until it
// reaches the most recent decision. It flips that decision, restores the
// decider index from the decider stack, and re-seeds BCP through the imply
// stack. The flipped literal is pushed as a forced entry, so a later
// conflict walks past it.

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 6
`endif

module backtrack_ctrl (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  // trace stack
  input  logic                        trace_empty,
  input  logic                        trace_type,
  input  logic                        trace_val,
  input  logic [`MAX_VARS_BITS-1:0]   trace_var,
  output logic                        trace_pop,
  output logic                        trace_push,
  output logic                        trace_push_type,
  output logic                        trace_push_val,
  output logic [`MAX_VARS_BITS-1:0]   trace_push_var,
  // decider stack / decider
  input  logic                        ds_empty,
  input  logic [`MAX_VARS_BITS-1:0]   ds_dec_idx,
  output logic                        ds_pop,
  output logic                        dec_write,
  output logic [`MAX_VARS_BITS-1:0]   dec_back_idx,
  // assignment memory
  output logic                        asgn_we,
  output logic                        asgn_clear,
  output logic [`MAX_VARS_BITS-1:0]   asgn_var,
  output logic                        asgn_val,
  // imply stack
  output logic                        imply_clear,
  output logic                        imply_push,
  output logic [`MAX_VARS_BITS-1:0]   imply_var,
  output logic                        imply_val,
  // status
  output logic                        busy,
  output logic                        done,
  output logic                        unsat,
  output logic                        err,
  output logic [`MAX_VARS_BITS:0]     bt_count
);

  localparam int W  = `MAX_VARS_BITS;
  localparam int CW = W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALK,
    ST_FLIP,
    ST_DONE,
    ST_UNSAT
  } state_t;

  state_t          state_reg, state_next;
  logic            first_walk_reg, first_walk_next;
  logic [CW-1:0]   bt_count_reg, bt_count_next;
  logic [W-1:0]    flip_var_reg, flip_var_next;
  logic            flip_val_reg, flip_val_next;
  logic            err_reg, err_next;
  logic [CW-1:0]   bt_count_inc;

  // Pop counter saturates instead of wrapping on very deep walks.
  assign bt_count_inc = (bt_count_reg == {CW{1'b1}}) ? bt_count_reg
                                                      : bt_count_reg + CW'(1);

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      first_walk_reg <= 1'b0;
      bt_count_reg   <= '0;
      flip_var_reg   <= '0;
      flip_val_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      first_walk_reg <= first_walk_next;
      bt_count_reg   <= bt_count_next;
      flip_var_reg   <= flip_var_next;
      flip_val_reg   <= flip_val_next;
      err_reg        <= err_next;
    end
  end

  // Next-state logic and combinational stack/memory commands.
  always_comb begin
    state_next      = state_reg;
    first_walk_next = 1'b0;
    bt_count_next   = bt_count_reg;
    flip_var_next   = flip_var_reg;
    flip_val_next   = flip_val_reg;
    err_next        = err_reg;

    trace_pop       = 1'b0;
    trace_push      = 1'b0;
    trace_push_type = 1'b0;
    trace_push_val  = 1'b0;
    trace_push_var  = '0;
    ds_pop          = 1'b0;
    dec_write       = 1'b0;
    dec_back_idx    = '0;
    asgn_we         = 1'b0;
    asgn_clear      = 1'b0;
    asgn_var        = '0;
    asgn_val        = 1'b0;
    imply_clear     = 1'b0;
    imply_push      = 1'b0;
    imply_var       = '0;
    imply_val       = 1'b0;
    done            = 1'b0;
    unsat           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next      = ST_WALK;
          first_walk_next = 1'b1;
          bt_count_next   = '0;
        end
      end

      ST_WALK: begin
        // The imply stack is flushed once, on entry to the walk.
        imply_clear = first_walk_reg;
        if (trace_empty) begin
          // No decision left to flip: the formula is unsatisfiable.
          state_next = ST_UNSAT;
        end else if (trace_type) begin
          trace_pop     = 1'b1;
          asgn_we       = 1'b1;
          asgn_clear    = 1'b1;
          asgn_var      = trace_var;
          bt_count_next = bt_count_inc;
        end else if (!ds_empty) begin
          trace_pop     = 1'b1;
          bt_count_next = bt_count_inc;
          asgn_we       = 1'b1;
          asgn_var      = trace_var;
          asgn_val      = ~trace_val;
          ds_pop        = 1'b1;
          dec_write     = 1'b1;
          dec_back_idx  = ds_dec_idx;
          flip_var_next = trace_var;
          flip_val_next = ~trace_val;
          state_next    = ST_FLIP;
        end else begin
          // A decision with no matching decider entry is an inconsistency.
          err_next   = 1'b1;
          state_next = ST_UNSAT;
        end
      end

      ST_FLIP: begin
        trace_push      = 1'b1;
        trace_push_type = 1'b1;
        trace_push_var  = flip_var_reg;
        trace_push_val  = flip_val_reg;
        imply_push      = 1'b1;
        imply_var       = flip_var_reg;
        imply_val       = flip_val_reg;
        state_next      = ST_DONE;
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      ST_UNSAT: begin
        unsat = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_reg == ST_WALK) || (state_reg == ST_FLIP) ||
                    (state_reg == ST_DONE);
  assign err      = err_reg;
  assign bt_count = bt_count_reg;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Testbench for backtrack_ctrl: behavioural trace/decider stacks around the
// DUT, per-cycle scoreboard of expected stack/memory transactions, table of
// stack layouts, plus hand-written corner sequences.

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 6
`endif

module tb_backtrack_ctrl;

  localparam int W     = `MAX_VARS_BITS;
  localparam int BTMAX = (1 << (W + 1)) - 1;

  localparam int K_ICLR  = 0;
  localparam int K_CLR   = 1;
  localparam int K_SET   = 2;
  localparam int K_DEC   = 3;
  localparam int K_STRAY = 4;
  localparam int K_TPUSH = 5;
  localparam int K_IPUSH = 6;
  localparam int K_DONE  = 7;

  logic          clock, reset, start;
  logic          trace_empty, trace_type, trace_val;
  logic [W-1:0]  trace_var;
  logic          trace_pop, trace_push, trace_push_type, trace_push_val;
  logic [W-1:0]  trace_push_var;
  logic          ds_empty;
  logic [W-1:0]  ds_dec_idx;
  logic          ds_pop, dec_write;
  logic [W-1:0]  dec_back_idx;
  logic          asgn_we, asgn_clear, asgn_val;
  logic [W-1:0]  asgn_var;
  logic          imply_clear, imply_push, imply_val;
  logic [W-1:0]  imply_var;
  logic          busy, done, unsat, err;
  logic [W:0]    bt_count;

  typedef struct packed {
    logic         typ;
    logic         val;
    logic [W-1:0] v;
  } tent_t;

  typedef struct packed {
    int           cyc;
    int           kind;
    logic [W-1:0] v;
    logic [1:0]   val;
  } ev_t;

  typedef struct {
    int             n;
    logic [2:0]     typ;     // bit i = entry i, entry 0 is the top
    logic [2:0]     val;
    logic [3*W-1:0] vars;
    bit             ds_is_empty;
    logic [W-1:0]   ds_top;
    int             exp_bt;
    bit             exp_unsat;
    bit             exp_err;
    int             exp_depth;
  } scen_t;

  tent_t tq[$];
  logic [W-1:0] dq[$];
  ev_t exp_q[$];
  scen_t tbl[5];

  int checks = 0;
  int errors = 0;

  backtrack_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .trace_empty(trace_empty), .trace_type(trace_type), .trace_val(trace_val),
    .trace_var(trace_var), .trace_pop(trace_pop), .trace_push(trace_push),
    .trace_push_type(trace_push_type), .trace_push_val(trace_push_val),
    .trace_push_var(trace_push_var),
    .ds_empty(ds_empty), .ds_dec_idx(ds_dec_idx), .ds_pop(ds_pop),
    .dec_write(dec_write), .dec_back_idx(dec_back_idx),
    .asgn_we(asgn_we), .asgn_clear(asgn_clear), .asgn_var(asgn_var),
    .asgn_val(asgn_val),
    .imply_clear(imply_clear), .imply_push(imply_push), .imply_var(imply_var),
    .imply_val(imply_val),
    .busy(busy), .done(done), .unsat(unsat), .err(err), .bt_count(bt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic string kname(input int k);
    case (k)
      K_ICLR:  return "imply_clear";
      K_CLR:   return "asgn_clear";
      K_SET:   return "asgn_set";
      K_DEC:   return "dec_write";
      K_STRAY: return "stray_pop";
      K_TPUSH: return "trace_push";
      K_IPUSH: return "imply_push";
      K_DONE:  return "done";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, expv);
    end
  endtask

  task automatic drive_inputs();
    if (tq.size() == 0) begin
      trace_empty = 1'b1;
      trace_type  = 1'b0;
      trace_val   = 1'b0;
      trace_var   = '0;
    end else begin
      trace_empty = 1'b0;
      trace_type  = tq[tq.size()-1].typ;
      trace_val   = tq[tq.size()-1].val;
      trace_var   = tq[tq.size()-1].v;
    end
    ds_empty   = (dq.size() == 0);
    ds_dec_idx = (dq.size() == 0) ? '0 : dq[dq.size()-1];
  endtask

  task automatic expect_ev(input int c, input int k, input logic [W-1:0] v, input logic [1:0] val);
    ev_t e;
    e.cyc = c; e.kind = k; e.v = v; e.val = val;
    exp_q.push_back(e);
  endtask

  // Expected transactions derived from the stack contents before start.
  task automatic gen_expected();
    int c;
    c = 1;
    expect_ev(1, K_ICLR, '0, 2'b00);
    for (int i = tq.size() - 1; i >= 0; i--) begin
      if (tq[i].typ) begin
        expect_ev(c, K_CLR, tq[i].v, 2'b01);
        c++;
      end else begin
        if (dq.size() != 0) begin
          expect_ev(c, K_SET, tq[i].v, {1'b1, ~tq[i].val});
          expect_ev(c, K_DEC, dq[dq.size()-1], 2'b01);
          expect_ev(c + 1, K_TPUSH, tq[i].v, {1'b1, ~tq[i].val});
          expect_ev(c + 1, K_IPUSH, tq[i].v, {1'b0, ~tq[i].val});
          expect_ev(c + 2, K_DONE, '0, 2'b01);
        end
        break;
      end
    end
  endtask

  task automatic check_ev(input int c, input int k, input logic [W-1:0] v, input logic [1:0] val);
    ev_t e;
    checks++;
    $display("txn cyc=%0d %s var=%0d val=%0d", c, kname(k), v, val);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL txn_unexpected got cyc=%0d %s var=%0d val=%0d required none",
               c, kname(k), v, val);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != c || e.kind != k || e.v !== v || e.val !== val) begin
        errors++;
        $display("FAIL txn got cyc=%0d %s var=%0d val=%0d required cyc=%0d %s var=%0d val=%0d",
                 c, kname(k), v, val, e.cyc, kname(e.kind), e.v, e.val);
      end
    end
  endtask

  task automatic monitor(input int c);
    if (imply_clear)           check_ev(c, K_ICLR, '0, 2'b00);
    if (asgn_we && asgn_clear) check_ev(c, K_CLR, asgn_var, {1'b0, trace_pop});
    if (asgn_we && !asgn_clear) check_ev(c, K_SET, asgn_var, {trace_pop, asgn_val});
    if (dec_write)             check_ev(c, K_DEC, dec_back_idx, {1'b0, ds_pop});
    if ((trace_pop != asgn_we) || (ds_pop != dec_write))
      check_ev(c, K_STRAY, '0, {trace_pop, ds_pop});
    if (trace_push)            check_ev(c, K_TPUSH, trace_push_var, {trace_push_type, trace_push_val});
    if (imply_push)            check_ev(c, K_IPUSH, imply_var, {1'b0, imply_val});
    if (done)                  check_ev(c, K_DONE, '0, {1'b0, busy});
  endtask

  // Runs ncyc cycles from cycle 0; start pulses in cycle 0 when start0 is
  // set and again in cycle start2 (if non-negative).
  task automatic run(input int ncyc, input bit start0, input int start2);
    logic tp, tpu, dp;
    tent_t pe;
    start = start0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      monitor(c);
      tp = trace_pop; tpu = trace_push; dp = ds_pop;
      pe.typ = trace_push_type; pe.val = trace_push_val; pe.v = trace_push_var;
      @(posedge clock);
      #1;
      if (tp && tq.size() > 0) void'(tq.pop_back());
      if (tpu) tq.push_back(pe);
      if (dp && dq.size() > 0) void'(dq.pop_back());
      start = (c + 1 == start2);
      drive_inputs();
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    tq.delete();
    dq.delete();
    exp_q.delete();
    drive_inputs();
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input int s);
    tent_t e;
    for (int i = tbl[s].n - 1; i >= 0; i--) begin
      e.typ = tbl[s].typ[i];
      e.val = tbl[s].val[i];
      e.v   = tbl[s].vars[i*W +: W];
      tq.push_back(e);
    end
    if (!tbl[s].ds_is_empty) dq.push_back(tbl[s].ds_top);
    drive_inputs();
  endtask

  task automatic final_checks(input string tag, input int bt, input bit un, input bit er, input int depth);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_txn got=%0d_left required=0 next=%s cyc=%0d",
               tag, exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
      exp_q.delete();
    end
    @(negedge clock);
    check({tag, "_bt_count"}, 64'(bt_count), 64'(bt));
    check({tag, "_unsat"}, 64'(unsat), 64'(un));
    check({tag, "_err"}, 64'(err), 64'(er));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_depth"}, 64'(tq.size()), 64'(depth));
    $display("summary %s bt_count=%0d unsat=%0d err=%0d depth=%0d", tag, bt_count, unsat, err, tq.size());
  endtask

  function automatic logic any_out();
    return |{trace_pop, trace_push, trace_push_type, trace_push_val, trace_push_var,
             ds_pop, dec_write, dec_back_idx, asgn_we, asgn_clear, asgn_var, asgn_val,
             imply_clear, imply_push, imply_var, imply_val, busy, done, unsat, err, bt_count};
  endfunction

  initial begin
    tent_t e;
    reset = 1'b1;
    start = 1'b0;
    drive_inputs();

    tbl[0] = '{3, 3'b011, 3'b101, {W'(2), W'(5), W'(3)},  1'b0, W'(7),  3, 1'b0, 1'b0, 1};
    tbl[1] = '{1, 3'b000, 3'b000, {W'(0), W'(0), W'(1)},  1'b0, W'(4),  1, 1'b0, 1'b0, 1};
    tbl[2] = '{2, 3'b011, 3'b011, {W'(0), W'(6), W'(4)},  1'b0, W'(5),  2, 1'b1, 1'b0, 0};
    tbl[3] = '{1, 3'b000, 3'b001, {W'(0), W'(0), W'(2)},  1'b1, W'(0),  0, 1'b1, 1'b1, 1};
    tbl[4] = '{3, 3'b001, 3'b010, {W'(10), W'(8), W'(9)}, 1'b0, W'(11), 2, 1'b0, 1'b0, 2};

    // Reset state.
    do_reset();
    @(negedge clock);
    check("reset_outputs_zero", 64'(any_out()), 64'd0);

    // Table-driven scenarios.
    for (int s = 0; s < 5; s++) begin
      do_reset();
      load(s);
      gen_expected();
      run(tbl[s].n + 6, 1'b1, -1);
      final_checks($sformatf("scen%0d", s), tbl[s].exp_bt, tbl[s].exp_unsat,
                   tbl[s].exp_err, tbl[s].exp_depth);
    end

    // start in UNSAT is ignored: no transactions, status unchanged.
    do_reset();
    load(2);
    gen_expected();
    run(8, 1'b1, -1);
    final_checks("unsat_pre", 2, 1'b1, 1'b0, 0);
    run(5, 1'b1, -1);
    final_checks("unsat_restart", 2, 1'b1, 1'b0, 0);

    // start pulsed during FLIP (cycle 3 with one forced entry above the
    // decision) is ignored: one done and unchanged depth.
    do_reset();
    load(4);
    gen_expected();
    run(10, 1'b1, 3);
    final_checks("start_in_flip", 2, 1'b0, 1'b0, 2);

    // Reset asserted in cycle 2 of the first scenario.
    do_reset();
    load(0);
    gen_expected();
    run(2, 1'b1, -1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("midreset_outputs_zero", 64'(any_out()), 64'd0);
    check("midreset_bt_count", 64'(bt_count), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    @(negedge clock);
    check("midreset_idle_next", 64'(busy), 64'd0);

    // Saturating pop counter on a deep all-forced walk.
    do_reset();
    for (int i = 0; i < BTMAX + 3; i++) begin
      e.typ = 1'b1;
      e.val = i[0];
      e.v   = W'(i);
      tq.push_back(e);
    end
    dq.push_back(W'(1));
    drive_inputs();
    gen_expected();
    run(BTMAX + 9, 1'b1, -1);
    final_checks("saturate", BTMAX, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
